// File: rtl/uart_cmd_parser_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_cmd_parser_if
// Purpose  : Bundles the byte input from the UART receiver and the published
//            position/phase outputs of the command parser.
// Ports    : rx_data/rx_rdy   - received byte and its ready level
//            pos_x/pos_y      - clamped levitation-centre coordinates
//            delay            - 10-bit phase delay (1024 counts = 360 deg)
//            upd              - one-cycle commit strobe
//            busy/led/err_cnt - frame-in-progress, status LED (active low),
//                               saturating aborted-frame count
// Modports : master - byte source / output consumer
//            slave  - the parser itself
// Revision : 1.0 - initial release
// ============================================================================
interface uart_cmd_parser_if;
    logic [7:0] rx_data;
    logic       rx_rdy;
    logic [2:0] pos_x;
    logic [2:0] pos_y;
    logic [9:0] delay;
    logic       upd;
    logic       busy;
    logic       led;
    logic [7:0] err_cnt;

    modport master (
        output rx_data, rx_rdy,
        input  pos_x, pos_y, delay, upd, busy, led, err_cnt
    );

    modport slave (
        input  rx_data, rx_rdy,
        output pos_x, pos_y, delay, upd, busy, led, err_cnt
    );
endinterface
`default_nettype wire

// File: rtl/uart_cmd_parser.sv
`default_nettype none
// ============================================================================
// Module   : uart_cmd_parser
// Purpose  : Assembles 4-byte command frames (FF, cmd, phase, 3C) from the
//            UART receiver, moves the levitation centre within a clamped
//            grid and publishes the phase delay with a one-cycle strobe.
// Ports    : clk   - system clock (same clock as the UART modules)
//            rst_n - asynchronous reset, active low
//            bus   - uart_cmd_parser_if.slave (byte in, registered outputs)
// Params   : TIMEOUT_CYC - idle cycles allowed between bytes of a frame (>=2)
//            GRID_MAX    - largest legal centre coordinate
//            INIT_X/Y    - reset coordinates
// Revision : 1.0 - initial release
// ============================================================================
module uart_cmd_parser #(
    parameter int TIMEOUT_CYC = 250000,
    parameter int GRID_MAX    = 4,
    parameter int INIT_X      = 3,
    parameter int INIT_Y      = 3
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    uart_cmd_parser_if.slave   bus
);

    localparam int             c_TMR_W    = $clog2(TIMEOUT_CYC);
    localparam logic [c_TMR_W-1:0] c_TMR_LAST = c_TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [2:0]     c_GRID_MAX = 3'(GRID_MAX);
    localparam logic [7:0]     c_HEADER   = 8'hFF;
    localparam logic [7:0]     c_TRAILER  = 8'h3C;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HDR  = 2'd1,
        S_CMD  = 2'd2,
        S_PH   = 2'd3
    } state_t;

    state_t             r_state;
    logic               r_rdy_q;
    logic [c_TMR_W-1:0] r_tmr;
    logic [7:0]         r_cmd;
    logic [7:0]         r_phase;
    logic [2:0]         r_pos_x;
    logic [2:0]         r_pos_y;
    logic [9:0]         r_delay;
    logic               r_upd;
    logic               r_busy;
    logic               r_led;
    logic [7:0]         r_err_cnt;

    // rx_rdy is a level; only its rising edge counts as a new byte, so a
    // level held high is consumed exactly once.
    logic w_byte_evt;
    assign w_byte_evt = bus.rx_rdy & ~r_rdy_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_rdy_q   <= 1'b0;
            r_tmr     <= '0;
            r_cmd     <= 8'd0;
            r_phase   <= 8'd0;
            r_pos_x   <= 3'(INIT_X);
            r_pos_y   <= 3'(INIT_Y);
            r_delay   <= 10'd0;
            r_upd     <= 1'b0;
            r_busy    <= 1'b0;
            r_led     <= 1'b1;
            r_err_cnt <= 8'd0;
        end else begin
            r_rdy_q <= bus.rx_rdy;
            r_upd   <= 1'b0;

            // A byte event takes priority over timer expiry in the same cycle.
            if (w_byte_evt) begin
                r_tmr <= '0;
                case (r_state)
                    S_IDLE: begin
                        if (bus.rx_data == c_HEADER) begin
                            r_state <= S_HDR;
                            r_busy  <= 1'b1;
                            r_led   <= 1'b0;
                        end else begin
                            r_led   <= 1'b1;
                        end
                    end
                    S_HDR: begin
                        r_cmd   <= bus.rx_data;
                        r_state <= S_CMD;
                    end
                    S_CMD: begin
                        r_phase <= bus.rx_data;
                        r_state <= S_PH;
                    end
                    S_PH: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        if (bus.rx_data == c_TRAILER) begin
                            // Commit: move the centre with clamping (no wrap).
                            case (r_cmd)
                                8'h41: if (r_pos_x != 3'd0)       r_pos_x <= r_pos_x - 3'd1;
                                8'h44: if (r_pos_x <  c_GRID_MAX) r_pos_x <= r_pos_x + 3'd1;
                                8'h57: if (r_pos_y <  c_GRID_MAX) r_pos_y <= r_pos_y + 3'd1;
                                8'h53: if (r_pos_y != 3'd0)       r_pos_y <= r_pos_y - 3'd1;
                                default: ;
                            endcase
                            r_delay <= {r_phase, 2'b00};
                            r_upd   <= 1'b1;
                        end else begin
                            r_led <= 1'b1;
                            if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end else if (r_state != S_IDLE) begin
                if (r_tmr == c_TMR_LAST) begin
                    // Inter-byte gap too long: drop the partial frame.
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_led   <= 1'b1;
                    r_tmr   <= '0;
                    if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
                end else begin
                    r_tmr <= r_tmr + 1'b1;
                end
            end
        end
    end

    assign bus.pos_x   = r_pos_x;
    assign bus.pos_y   = r_pos_y;
    assign bus.delay   = r_delay;
    assign bus.upd     = r_upd;
    assign bus.busy    = r_busy;
    assign bus.led     = r_led;
    assign bus.err_cnt = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_parser.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_cmd_parser
// Purpose  : Self-checking bench for uart_cmd_parser: a table of frames with
//            hand-computed expected outputs, plus directed sequences for
//            timeout, expiry-cycle byte, mid-frame reset and held rx_rdy.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_cmd_parser;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    int   upd_pulses;

    uart_cmd_parser_if bus ();

    uart_cmd_parser #(
        .TIMEOUT_CYC (100),
        .GRID_MAX    (4),
        .INIT_X      (3),
        .INIT_Y      (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (bus.upd === 1'b1) upd_pulses++;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0] cmd;
        logic [7:0] ph;
        logic [7:0] trl;
        int         x;
        int         y;
        int         d;
        int         upd;
        int         err;
        int         led;
    } vec_t;

    vec_t vecs [18];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One byte: rx_rdy high for the event edge, then low for one edge.
    task automatic send_byte(input logic [7:0] b);
        bus.rx_data = b;
        bus.rx_rdy  = 1'b1;
        wait_edges(1);
        bus.rx_rdy  = 1'b0;
        wait_edges(1);
    endtask

    // Final byte of a frame; snapshots outputs right after the event edge
    // and the strobe one edge later.
    task automatic send_last(input logic [7:0] b,
                             output int x, output int y, output int d,
                             output int u, output int e, output int l,
                             output int bz, output int u_after);
        bus.rx_data = b;
        bus.rx_rdy  = 1'b1;
        wait_edges(1);
        x  = int'(bus.pos_x);
        y  = int'(bus.pos_y);
        d  = int'(bus.delay);
        u  = int'(bus.upd);
        e  = int'(bus.err_cnt);
        l  = int'(bus.led);
        bz = int'(bus.busy);
        bus.rx_rdy = 1'b0;
        wait_edges(1);
        u_after = int'(bus.upd);
    endtask

    task automatic check_frame(input string tag, input int ex, input int ey,
                               input int ed, input int eu, input int ee,
                               input int el, input logic [7:0] trl);
        int x, y, d, u, e, l, bz, ua;
        send_last(trl, x, y, d, u, e, l, bz, ua);
        chk({tag, ".pos_x"},   x,  ex);
        chk({tag, ".pos_y"},   y,  ey);
        chk({tag, ".delay"},   d,  ed);
        chk({tag, ".upd"},     u,  eu);
        chk({tag, ".err_cnt"}, e,  ee);
        chk({tag, ".led"},     l,  el);
        chk({tag, ".busy"},    bz, 0);
        chk({tag, ".upd_fall"}, ua, 0);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, ".pos_x"},   int'(bus.pos_x),   3);
        chk({tag, ".pos_y"},   int'(bus.pos_y),   3);
        chk({tag, ".delay"},   int'(bus.delay),   0);
        chk({tag, ".upd"},     int'(bus.upd),     0);
        chk({tag, ".busy"},    int'(bus.busy),    0);
        chk({tag, ".led"},     int'(bus.led),     1);
        chk({tag, ".err_cnt"}, int'(bus.err_cnt), 0);
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        upd_pulses = 0;

        //            cmd    ph     trl    x  y  d     upd err led
        vecs[0]  = '{8'h44, 8'h10, 8'h3C, 4, 3, 64,   1, 0, 0};
        vecs[1]  = '{8'h44, 8'h00, 8'h3C, 4, 3, 0,    1, 0, 0};
        vecs[2]  = '{8'h44, 8'h00, 8'h3C, 4, 3, 0,    1, 0, 0};
        vecs[3]  = '{8'h41, 8'h00, 8'h3C, 3, 3, 0,    1, 0, 0};
        vecs[4]  = '{8'h41, 8'h00, 8'h3C, 2, 3, 0,    1, 0, 0};
        vecs[5]  = '{8'h41, 8'h00, 8'h3C, 1, 3, 0,    1, 0, 0};
        vecs[6]  = '{8'h41, 8'h00, 8'h3C, 0, 3, 0,    1, 0, 0};
        vecs[7]  = '{8'h41, 8'h00, 8'h3C, 0, 3, 0,    1, 0, 0};
        vecs[8]  = '{8'h57, 8'h00, 8'h3C, 0, 4, 0,    1, 0, 0};
        vecs[9]  = '{8'h57, 8'h00, 8'h3C, 0, 4, 0,    1, 0, 0};
        vecs[10] = '{8'h53, 8'hFF, 8'h3C, 0, 3, 1020, 1, 0, 0};
        vecs[11] = '{8'h53, 8'h01, 8'h3C, 0, 2, 4,    1, 0, 0};
        vecs[12] = '{8'h53, 8'h02, 8'h3C, 0, 1, 8,    1, 0, 0};
        vecs[13] = '{8'h53, 8'h03, 8'h3C, 0, 0, 12,   1, 0, 0};
        vecs[14] = '{8'h53, 8'h04, 8'h3C, 0, 0, 16,   1, 0, 0};
        vecs[15] = '{8'h58, 8'h05, 8'h3C, 0, 0, 20,   1, 0, 0};
        vecs[16] = '{8'h41, 8'h20, 8'h3B, 0, 0, 20,   0, 1, 1};
        vecs[17] = '{8'h44, 8'h7F, 8'h3C, 1, 0, 508,  1, 1, 0};

        bus.rx_data = 8'h00;
        bus.rx_rdy  = 1'b0;
        rst_n       = 1'b0;
        wait_edges(3);
        check_reset_state("reset");
        rst_n = 1'b1;
        wait_edges(2);

        // Header alone: frame in progress, LED on.
        send_byte(8'hFF);
        chk("hdr.busy", int'(bus.busy), 1);
        chk("hdr.led",  int'(bus.led),  0);
        send_byte(vecs[0].cmd);
        send_byte(vecs[0].ph);
        check_frame("vec0", vecs[0].x, vecs[0].y, vecs[0].d, vecs[0].upd,
                    vecs[0].err, vecs[0].led, vecs[0].trl);

        for (int i = 1; i < 18; i++) begin
            send_byte(8'hFF);
            send_byte(vecs[i].cmd);
            send_byte(vecs[i].ph);
            check_frame($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].d,
                        vecs[i].upd, vecs[i].err, vecs[i].led, vecs[i].trl);
        end

        // Timeout: 100 idle cycles after the last byte abort the frame.
        send_byte(8'hFF);
        send_byte(8'h41);
        wait_edges(98);
        chk("tmo.busy_before", int'(bus.busy), 1);
        wait_edges(1);
        chk("tmo.busy",    int'(bus.busy),    0);
        chk("tmo.err_cnt", int'(bus.err_cnt), 2);
        chk("tmo.led",     int'(bus.led),     1);
        chk("tmo.pos_x",   int'(bus.pos_x),   1);
        chk("tmo.delay",   int'(bus.delay),   508);

        // Good frame after a timeout.
        send_byte(8'hFF);
        send_byte(8'h44);
        send_byte(8'h08);
        check_frame("post_tmo", 2, 0, 32, 1, 2, 0, 8'h3C);

        // Byte landing exactly on the expiry cycle is accepted.
        send_byte(8'hFF);
        send_byte(8'h41);
        wait_edges(98);
        bus.rx_data = 8'h21;
        bus.rx_rdy  = 1'b1;
        wait_edges(1);
        bus.rx_rdy  = 1'b0;
        chk("expiry.busy",    int'(bus.busy),    1);
        chk("expiry.err_cnt", int'(bus.err_cnt), 2);
        wait_edges(1);
        check_frame("expiry", 1, 0, 132, 1, 2, 0, 8'h3C);

        // Reset mid-frame discards the partial frame.
        send_byte(8'hFF);
        send_byte(8'h44);
        rst_n = 1'b0;
        #1;
        check_reset_state("midrst");
        wait_edges(2);
        rst_n = 1'b1;
        wait_edges(2);
        check_reset_state("postrst");

        // rx_rdy held high consumes one byte only.
        bus.rx_data = 8'hFF;
        bus.rx_rdy  = 1'b1;
        wait_edges(50);
        chk("held.busy", int'(bus.busy), 1);
        chk("held.led",  int'(bus.led),  0);
        bus.rx_rdy = 1'b0;
        wait_edges(1);
        send_byte(8'h44);
        send_byte(8'h00);
        check_frame("held", 4, 3, 0, 1, 0, 0, 8'h3C);

        wait_edges(2);
        chk("upd_pulse_count", upd_pulses, 20);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
